// File: rtl/csa_mult_seq_pkg.sv
// ---------------------------------------------------------------------------
// csa_mult_pkg
//   Shared definitions for the sequential carry-save multiplier:
//   default operand width, FSM state encoding and the width helper for
//   the partial-product index counter.
// ---------------------------------------------------------------------------
package csa_mult_pkg;

    localparam int DEF_WIDTH = 8;

    // FSM encoding, kept as plain constants so the state register stays a
    // simple vector in netlists and older tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ACCUM   = 2'd1;
    localparam state_t ST_RESOLVE = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    // Width of the partial-product index k (0..w-1); never narrower than 1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/csa_mult_seq_if.sv
// ---------------------------------------------------------------------------
// csa_mult_seq_if
//   Request/response bundle of the sequential carry-save multiplier.
//   Ports (from the requester's side, modport master):
//     start  out  request, sampled only while the multiplier is idle
//     A, B   out  unsigned operands, sampled together with start
//     busy   in   operation in progress
//     done   in   one-cycle completion pulse, P valid
//     P      in   product, held until the next accepted start
//   The multiplier connects through modport slave.
// ---------------------------------------------------------------------------
interface csa_mult_seq_if
    import csa_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (
        output start, A, B,
        input  busy, done, P
    );

    modport slave (
        input  start, A, B,
        output busy, done, P
    );

endinterface

// File: rtl/csa_mult_seq_row.sv
// ---------------------------------------------------------------------------
// csa_row
//   One row of N independent full-adder cells (3:2 compressor).
//   Ports:
//     x_i, y_i, z_i  in   N-bit addends
//     s_o            out  bitwise sum   x ^ y ^ z
//     c_o            out  bitwise carry maj(x, y, z), not shifted; the
//                         caller aligns it one position up
//   Purely combinational; this is the only adder resource of the multiplier.
// ---------------------------------------------------------------------------
module csa_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] z_i,
    output logic [N-1:0] s_o,
    output logic [N-1:0] c_o
);

    assign s_o = x_i ^ y_i ^ z_i;
    assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);

endmodule

// File: rtl/csa_mult_seq.sv
// ---------------------------------------------------------------------------
// csa_mult_seq
//   Low-area unsigned multiplier. A single 2*WIDTH-bit carry-save row is
//   time-shared: WIDTH cycles fold one partial product per cycle into a
//   redundant sum/carry pair, then the same row (with a zero third input)
//   ripples the carry vector out until it is all-zero, leaving the product
//   in the sum register.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous active-high reset; drops any operation in flight
//     bus  slave side of csa_mult_seq_if (start/A/B in, busy/done/P out)
//   All outputs come straight from registers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; operands latched on acceptance
//   ACCUM   | WIDTH cycles, one partial product b[k]*a<<k added per cycle
//   RESOLVE | carry-save pair collapsed; exits when carry is zero
//   DONE    | one cycle, done pulse, P valid
// ---------------------------------------------------------------------------
module csa_mult_seq
    import csa_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    csa_mult_seq_if.slave      bus
);

    localparam int PW = 2 * WIDTH;
    localparam int KW = cnt_width(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [PW-1:0]      sum_q, sum_d;
    logic [PW-1:0]      carry_q, carry_d;
    logic [PW-1:0]      p_q, p_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   pp_bits;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      row_z;
    logic [PW-1:0]      row_s;
    logic [PW-1:0]      row_c;
    logic [PW-1:0]      carry_sh;

    // Partial product for the current multiplier bit, aligned to weight k.
    assign pp_bits = a_q & {WIDTH{b_q[k_q]}};
    assign pp      = {{WIDTH{1'b0}}, pp_bits} << k_q;

    // RESOLVE reuses the row as a two-input half-adder stage.
    assign row_z = (state_q == ST_ACCUM) ? pp : '0;

    csa_row #(
        .N (PW)
    ) u_row (
        .x_i (sum_q),
        .y_i (carry_q),
        .z_i (row_z),
        .s_o (row_s),
        .c_o (row_c)
    );

    // Carry moves up one weight; the MSB falls off because the true product
    // always fits in PW bits, so the mod-2^PW arithmetic stays exact.
    assign carry_sh = {row_c[PW-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        p_d     = p_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sum_d   = '0;
                    carry_d = '0;
                    k_d     = '0;
                    state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                sum_d   = row_s;
                carry_d = carry_sh;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_RESOLVE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            ST_RESOLVE: begin
                if (carry_q == '0) begin
                    p_d     = sum_q;
                    state_d = ST_DONE;
                end else begin
                    sum_d   = row_s;
                    carry_d = carry_sh;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they can be
        // registered and still line up with the state they describe.
        busy_d = (state_d == ST_ACCUM) || (state_d == ST_RESOLVE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.P    = p_q;

endmodule

// File: tb/tb_csa_mult_seq.sv
module tb_csa_mult_seq;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst;

    csa_mult_seq_if #(.WIDTH(W)) bus ();

    csa_mult_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; returns in cycle 1 of the accepted operation.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Called in cycle c0 of an operation; busy must stay high until done
    // appears. Returns the cycle index at which done was observed.
    task automatic wait_done(input string tag, input logic [PW-1:0] exp_p,
                             input int c0, output int lat);
        int c;
        c = c0;
        while (bus.done !== 1'b1 && c <= 3 * W + 6) begin
            chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            step();
            c++;
        end
        chk({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({tag, "_P"}, 64'(bus.P), 64'(exp_p));
        lat = c;
    endtask

    task automatic after_done(input string tag, input logic [PW-1:0] exp_p);
        step();
        chk({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_P_held"}, 64'(bus.P), 64'(exp_p));
    endtask

    logic [W-1:0]  ra, rb;
    logic [PW-1:0] rexp;
    int lat, pulses;

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) step();
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_P",    64'(bus.P),    64'd0);
        rst = 1'b0;
        step();

        // Warm-up operation so the reset test below sees a nonzero P.
        start_op(8'd11, 8'd13);
        wait_done("warm", 16'd143, 1, lat);
        after_done("warm", 16'd143);

        // Reset in cycle 4 of an operation.
        start_op(8'd200, 8'd100);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rstmid_busy", 64'(bus.busy), 64'd0);
        chk("rstmid_done", 64'(bus.done), 64'd0);
        chk("rstmid_P",    64'(bus.P),    64'd0);
        rst = 1'b0;
        step();
        chk("rstmid_still_idle", 64'(bus.busy), 64'd0);
        start_op(8'd3, 8'd5);
        wait_done("after_rst", 16'd15, 1, lat);
        chk("after_rst_lat_min", 64'(lat >= W + 2), 64'd1);
        after_done("after_rst", 16'd15);

        // Zero operands: no carries at all, minimum latency.
        start_op(8'd0, 8'd0);
        wait_done("zero", 16'd0, 1, lat);
        chk("zero_lat", 64'(lat), 64'(W + 2));
        after_done("zero", 16'd0);

        // Largest operands.
        start_op(8'd255, 8'd255);
        wait_done("max", 16'd65025, 1, lat);
        chk("max_lat_bound", 64'(lat <= 3 * W + 2), 64'd1);
        after_done("max", 16'd65025);

        // start pulsed during ACCUM and during DONE must be ignored.
        start_op(8'd7, 8'd9);
        step();
        step();
        bus.A     = 8'd1;
        bus.B     = 8'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("ignore", 16'd63, 4, lat);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ignore_done_one_cycle", 64'(bus.done), 64'd0);
        chk("ignore_not_restarted", 64'(bus.busy), 64'd0);
        pulses = 0;
        repeat (3 * W) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        chk("ignore_extra_done", 64'(pulses), 64'd0);
        chk("ignore_P", 64'(bus.P), 64'd63);

        // Back-to-back with start held high.
        bus.A     = 8'd12;
        bus.B     = 8'd13;
        bus.start = 1'b1;
        step();
        bus.A = 8'd255;
        bus.B = 8'd1;
        wait_done("b2b_first", 16'd156, 1, lat);
        step();
        chk("b2b_idle_gap_busy", 64'(bus.busy), 64'd0);
        chk("b2b_idle_gap_done", 64'(bus.done), 64'd0);
        chk("b2b_idle_gap_P",    64'(bus.P),    64'd156);
        step();
        chk("b2b_second_accepted", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done("b2b_second", 16'd255, 1, lat);
        chk("b2b_second_lat", 64'(lat >= W + 2 && lat <= 3 * W + 2), 64'd1);
        after_done("b2b_second", 16'd255);

        // Random regression against plain integer multiplication.
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            if (i % 10 == 0) ra = '1;
            if (i % 7 == 0)  rb = '1;
            rexp = PW'(ra) * PW'(rb);
            start_op(ra, rb);
            wait_done("rand", rexp, 1, lat);
            chk("rand_lat", 64'(lat >= W + 2 && lat <= 3 * W + 2), 64'd1);
            after_done("rand", rexp);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
